sub_bytes_seq: RTL and testbench

Time-multiplexed, parametrised AES byte-substitution engine supporting forward SubBytes and InvSubBytes on an NUMBYTES-wide state. It uses LANES S-box instances per cycle, so area and latency can be traded. It has a valid/ready handshake on both sides. It sits between the round-key adder and ShiftRows/InvShiftRows in the iterative cipher datapath, and is reused for the key-expansion SubWord with NUMBYTES=4.

---
 rtl/sub_bytes_seq.sv | 155 +++++++++++++++
 tb/tb_sub_bytes_seq.sv | 389 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module : sub_bytes_seq
// Brief  : Time-multiplexed AES SubBytes / InvSubBytes engine, LANES S-boxes
//          per cycle over an NUMBYTES-wide block, valid/ready on both sides.
// Rev    : 1.0  initial release
// ============================================================================
module sub_bytes_seq #(
   parameter int NUMBYTES = 16,
   parameter int LANES    = 4
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [8*NUMBYTES-1:0] in_data,
   input  logic                  in_inv,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [8*NUMBYTES-1:0] out_data,
   output logic                  busy
);

   localparam int c_groups = NUMBYTES / LANES;
   localparam int c_cnt_w  = (c_groups > 1) ? $clog2(c_groups) : 1;
   localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(c_groups - 1);

   if ((LANES < 1) || ((NUMBYTES % LANES) != 0)) begin : g_bad_lanes
      $error("sub_bytes_seq: LANES (%0d) must divide NUMBYTES (%0d)", LANES, NUMBYTES);
   end

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   // GF(2^8) multiply modulo x^8+x^4+x^3+x+1
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; maps 0 to 0 as the S-box requires
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] x2, x3, x6, x12, x15, x30, x60, x120, x240, x252;
      x2   = gf_mul(a, a);
      x3   = gf_mul(x2, a);
      x6   = gf_mul(x3, x3);
      x12  = gf_mul(x6, x6);
      x15  = gf_mul(x12, x3);
      x30  = gf_mul(x15, x15);
      x60  = gf_mul(x30, x30);
      x120 = gf_mul(x60, x60);
      x240 = gf_mul(x120, x120);
      x252 = gf_mul(x240, x12);
      return gf_mul(x252, x2);
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a, input logic inv);
      logic [7:0] t;
      logic [7:0] r;
      if (inv) begin
         t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
         r = gf_inv(t);
      end else begin
         t = gf_inv(a);
         r = t ^ {t[6:0], t[7]} ^ {t[5:0], t[7:6]} ^ {t[4:0], t[7:5]}
               ^ {t[3:0], t[7:4]} ^ 8'h63;
      end
      return r;
   endfunction

   state_t                r_state;
   state_t                w_state_nxt;
   logic [8*NUMBYTES-1:0] r_src;
   logic [8*NUMBYTES-1:0] r_res;
   logic                  r_inv;
   logic [c_cnt_w-1:0]    r_cnt;
   logic                  w_accept;
   logic [7:0]            w_lane_out [LANES];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      logic [7:0] w_lane_in;
      assign w_lane_in     = r_src[(int'(r_cnt) * LANES + l) * 8 +: 8];
      assign w_lane_out[l] = sbox(w_lane_in, r_inv);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else        r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      in_ready    = 1'b0;
      out_valid   = 1'b0;
      busy        = 1'b0;
      case (r_state)
         IDLE: begin
            in_ready = 1'b1;
            if (in_valid) w_state_nxt = BUSY;
         end
         BUSY: begin
            busy = 1'b1;
            if (r_cnt == c_last) w_state_nxt = DONE;
         end
         DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            if (out_ready) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   assign w_accept = in_valid && in_ready;
   assign out_data = r_res;

   // Result register is deliberately not cleared on accept; only reset clears it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_src <= '0;
         r_res <= '0;
         r_inv <= 1'b0;
         r_cnt <= '0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_src <= in_data;
                  r_inv <= in_inv;
                  r_cnt <= '0;
               end
            end
            BUSY: begin
               for (int l = 0; l < LANES; l++) begin
                  r_res[(int'(r_cnt) * LANES + l) * 8 +: 8] <= w_lane_out[l];
               end
               if (r_cnt != c_last) r_cnt <= r_cnt + 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sub_bytes_seq.sv
`default_nettype none
// ============================================================================
// Module : tb_sub_bytes_seq
// Brief  : Randomised self-checking bench for sub_bytes_seq against a
//          log/antilog-table S-box model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_sub_bytes_seq;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid, in_ready, in_inv, out_valid, out_ready, busy;
   logic [127:0] in_data, out_data;

   logic         s_in_valid, s_in_ready, s_in_inv, s_out_valid, s_out_ready, s_busy;
   logic [31:0]  s_in_data, s_out_data;

   logic         f_in_valid, f_in_ready, f_in_inv, f_out_valid, f_out_ready, f_busy;
   logic [127:0] f_in_data, f_out_data;

   int           n_vec = 0;
   int           n_err = 0;
   logic [7:0]   fwd_tbl [256];
   logic [7:0]   inv_tbl [256];

   always #5 clk = ~clk;

   sub_bytes_seq #(.NUMBYTES(16), .LANES(4)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .in_inv(in_inv), .out_valid(out_valid),
      .out_ready(out_ready), .out_data(out_data), .busy(busy)
   );

   sub_bytes_seq #(.NUMBYTES(4), .LANES(2)) dut_word (
      .clk(clk), .rst_n(rst_n), .in_valid(s_in_valid), .in_ready(s_in_ready),
      .in_data(s_in_data), .in_inv(s_in_inv), .out_valid(s_out_valid),
      .out_ready(s_out_ready), .out_data(s_out_data), .busy(s_busy)
   );

   sub_bytes_seq #(.NUMBYTES(16), .LANES(16)) dut_full (
      .clk(clk), .rst_n(rst_n), .in_valid(f_in_valid), .in_ready(f_in_ready),
      .in_data(f_in_data), .in_inv(f_in_inv), .out_valid(f_out_valid),
      .out_ready(f_out_ready), .out_data(f_out_data), .busy(f_busy)
   );

   // Reference S-boxes: inverse from generator-3 log tables, then the bitwise affine map
   task automatic build_tables;
      logic [7:0] alog [255];
      int         lg [256];
      logic [7:0] x, a, b, c_aff;
      c_aff = 8'h63;
      x = 8'h01;
      for (int i = 0; i < 255; i++) begin
         alog[i] = x;
         lg[x]   = i;
         x = x ^ ({x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00));
      end
      for (int v = 0; v < 256; v++) begin
         a = (v == 0) ? 8'h00 : alog[(255 - lg[v]) % 255];
         for (int i = 0; i < 8; i++)
            b[i] = a[i] ^ a[(i+4)%8] ^ a[(i+5)%8] ^ a[(i+6)%8] ^ a[(i+7)%8] ^ c_aff[i];
         fwd_tbl[v] = b;
         inv_tbl[b] = v[7:0];
      end
   endtask

   function automatic logic [127:0] ref_block(input logic [127:0] d, input logic inv);
      logic [127:0] r;
      for (int i = 0; i < 16; i++)
         r[8*i +: 8] = inv ? inv_tbl[d[8*i +: 8]] : fwd_tbl[d[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [31:0] ref_word(input logic [31:0] d, input logic inv);
      logic [31:0] r;
      for (int i = 0; i < 4; i++)
         r[8*i +: 8] = inv ? inv_tbl[d[8*i +: 8]] : fwd_tbl[d[8*i +: 8]];
      return r;
   endfunction

   function automatic logic [127:0] rand128();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   // Offers one block, waits for out_valid; lat = edges from accept to out_valid
   task automatic send(input logic [127:0] d, input logic inv,
                       output logic [127:0] res, output int lat);
      in_data  = d;
      in_inv   = inv;
      in_valid = 1'b1;
      lat = 0;
      while (!in_ready && lat < 50) begin @(posedge clk); #1; lat++; end
      @(posedge clk); #1;
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      res = out_data;
   endtask

   task automatic release_out;
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset;
      rst_n = 1'b0;
      in_valid = 1'b1; s_in_valid = 1'b1; f_in_valid = 1'b1;
      in_data = rand128(); in_inv = 1'b1;
      #1;
      repeat (3) begin
         @(posedge clk); #1;
         n_vec++;
         if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || out_data !== '0) begin
            n_err++;
            $display("FAIL reset: ready=%b valid=%b busy=%b data=%h, want 1 0 0 0",
                     in_ready, out_valid, busy, out_data);
         end
         n_vec++;
         if (s_out_data !== '0 || f_out_data !== '0 || s_busy !== 1'b0 || f_busy !== 1'b0) begin
            n_err++;
            $display("FAIL reset_variants: word=%h full=%h busy=%b%b, want 0 0 00",
                     s_out_data, f_out_data, s_busy, f_busy);
         end
      end
      in_valid = 1'b0; s_in_valid = 1'b0; f_in_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_vec++;
      if (in_ready !== 1'b1 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_release: ready=%b busy=%b, want 1 0", in_ready, busy);
      end
   endtask

   task automatic test_known_answer;
      logic [127:0] res, res2;
      int lat;
      send(128'h00112233445566778899AABBCCDDEEFF, 1'b0, res, lat);
      n_vec++;
      if (res !== 128'h638293C31BFC33F5C4EEACEA4BC12816) begin
         n_err++;
         $display("FAIL kat_fwd: got %h want 638293c31bfc33f5c4eeacea4bc12816", res);
      end
      n_vec++;
      if (lat !== 4) begin
         n_err++;
         $display("FAIL kat_latency: got %0d edges want 4", lat);
      end
      n_vec++;
      if (out_valid !== 1'b1 || busy !== 1'b1 || in_ready !== 1'b0) begin
         n_err++;
         $display("FAIL kat_done_flags: valid=%b busy=%b ready=%b, want 1 1 0",
                  out_valid, busy, in_ready);
      end
      release_out();
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
          out_data !== 128'h638293C31BFC33F5C4EEACEA4BC12816) begin
         n_err++;
         $display("FAIL kat_after_handshake: valid=%b ready=%b data=%h, want 0 1 held result",
                  out_valid, in_ready, out_data);
      end
      send(res, 1'b1, res2, lat);
      n_vec++;
      if (res2 !== 128'h00112233445566778899AABBCCDDEEFF) begin
         n_err++;
         $display("FAIL kat_inv: got %h want 00112233445566778899aabbccddeeff", res2);
      end
      release_out();
   endtask

   task automatic test_all_bytes;
      logic [127:0] d, res;
      int lat;
      for (int m = 0; m < 2; m++) begin
         for (int j = 0; j < 16; j++) begin
            for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(16*j + i);
            send(d, m[0], res, lat);
            n_vec++;
            if (res !== ref_block(d, m[0])) begin
               n_err++;
               $display("FAIL all_bytes mode=%0d blk=%0d: got %h want %h",
                        m, j, res, ref_block(d, m[0]));
            end
            if (m == 0 && j == 5) begin
               n_vec++;
               if (res[8*3 +: 8] !== 8'hED) begin
                  n_err++;
                  $display("FAIL sbox_53: got %h want ed", res[8*3 +: 8]);
               end
            end
            if (m == 1 && j == 1) begin
               n_vec++;
               if (res[8*6 +: 8] !== 8'hFF) begin
                  n_err++;
                  $display("FAIL invsbox_16: got %h want ff", res[8*6 +: 8]);
               end
            end
            release_out();
         end
      end
   endtask

   task automatic test_backpressure;
      logic [127:0] d, res, exp;
      logic inv;
      int lat;
      d = rand128();
      inv = 1'($urandom);
      exp = ref_block(d, inv);
      send(d, inv, res, lat);
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         in_data  = rand128();
         in_inv   = 1'($urandom);
         @(posedge clk); #1;
         n_vec++;
         if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== exp) begin
            n_err++;
            $display("FAIL backpressure cyc=%0d: valid=%b ready=%b data=%h, want 1 0 %h",
                     c, out_valid, in_ready, out_data, exp);
         end
      end
      in_valid = 1'b0;
      release_out();
   endtask

   task automatic test_reset_mid;
      logic [127:0] d, res;
      int lat;
      in_data  = rand128();
      in_inv   = 1'b0;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      rst_n = 1'b0;
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_data !== '0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_mid: valid=%b ready=%b busy=%b data=%h, want 0 1 0 0",
                  out_valid, in_ready, busy, out_data);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      d = rand128();
      send(d, 1'b1, res, lat);
      n_vec++;
      if (res !== ref_block(d, 1'b1) || lat !== 4) begin
         n_err++;
         $display("FAIL after_reset_mid: got %h lat=%0d want %h lat=4",
                  res, lat, ref_block(d, 1'b1));
      end
      release_out();
   endtask

   task automatic test_back_to_back;
      logic [127:0] blk [3];
      logic         mode [3];
      logic [127:0] od;
      int acc_cyc [3];
      int na, nr, cyc;
      bit acc, del;
      for (int i = 0; i < 3; i++) begin blk[i] = rand128(); mode[i] = 1'($urandom); end
      na = 0; nr = 0; cyc = 0;
      in_data = blk[0]; in_inv = mode[0]; in_valid = 1'b1; out_ready = 1'b1;
      while (nr < 3 && cyc < 100) begin
         acc = in_ready && in_valid;
         del = out_valid;
         od  = out_data;
         @(posedge clk); #1;
         cyc++;
         if (acc) begin
            acc_cyc[na] = cyc;
            na++;
            if (na < 3) begin in_data = blk[na]; in_inv = mode[na]; end
            else in_valid = 1'b0;
         end
         if (del) begin
            n_vec++;
            if (od !== ref_block(blk[nr], mode[nr])) begin
               n_err++;
               $display("FAIL b2b_data blk=%0d: got %h want %h", nr, od, ref_block(blk[nr], mode[nr]));
            end
            nr++;
         end
      end
      in_valid = 1'b0; out_ready = 1'b0;
      n_vec++;
      if (nr !== 3 || na !== 3) begin
         n_err++;
         $display("FAIL b2b_timeout: delivered %0d accepted %0d, want 3 3", nr, na);
      end else begin
         for (int i = 1; i < 3; i++) begin
            n_vec++;
            if (acc_cyc[i] - acc_cyc[i-1] !== 6) begin
               n_err++;
               $display("FAIL b2b_spacing %0d: got %0d cycles want 6", i, acc_cyc[i] - acc_cyc[i-1]);
            end
         end
      end
   endtask

   task automatic test_random;
      logic [127:0] d, res;
      logic inv;
      int lat;
      for (int k = 0; k < 8; k++) begin
         d = rand128();
         inv = 1'($urandom);
         send(d, inv, res, lat);
         n_vec++;
         if (res !== ref_block(d, inv) || lat !== 4) begin
            n_err++;
            $display("FAIL random %0d: got %h lat=%0d want %h lat=4", k, res, lat, ref_block(d, inv));
         end
         release_out();
      end
   endtask

   task automatic test_subword;
      logic [31:0] d;
      logic inv;
      int lat;
      for (int k = 0; k < 6; k++) begin
         d = $urandom;
         inv = 1'($urandom);
         s_in_data = d; s_in_inv = inv; s_in_valid = 1'b1;
         @(posedge clk); #1;
         s_in_valid = 1'b0;
         lat = 0;
         while (!s_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
         n_vec++;
         if (s_out_data !== ref_word(d, inv) || lat !== 2) begin
            n_err++;
            $display("FAIL subword %0d: got %h lat=%0d want %h lat=2", k, s_out_data, lat, ref_word(d, inv));
         end
         s_out_ready = 1'b1;
         @(posedge clk); #1;
         s_out_ready = 1'b0;
      end
   endtask

   task automatic test_full_lanes;
      logic [127:0] d;
      logic inv;
      int lat;
      for (int k = 0; k < 4; k++) begin
         d = rand128();
         inv = 1'($urandom);
         f_in_data = d; f_in_inv = inv; f_in_valid = 1'b1;
         @(posedge clk); #1;
         f_in_valid = 1'b0;
         lat = 0;
         while (!f_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
         n_vec++;
         if (f_out_data !== ref_block(d, inv) || lat !== 1) begin
            n_err++;
            $display("FAIL full_lanes %0d: got %h lat=%0d want %h lat=1", k, f_out_data, lat, ref_block(d, inv));
         end
         f_out_ready = 1'b1;
         @(posedge clk); #1;
         f_out_ready = 1'b0;
      end
   endtask

   initial begin
      build_tables();
      rst_n = 1'b0;
      in_valid = 1'b0; in_data = '0; in_inv = 1'b0; out_ready = 1'b0;
      s_in_valid = 1'b0; s_in_data = '0; s_in_inv = 1'b0; s_out_ready = 1'b0;
      f_in_valid = 1'b0; f_in_data = '0; f_in_inv = 1'b0; f_out_ready = 1'b0;
      test_reset();
      test_known_answer();
      test_all_bytes();
      test_backpressure();
      test_reset_mid();
      test_back_to_back();
      test_random();
      test_subword();
      test_full_lanes();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
